delay_timer_arbiter: RTL and testbench

Shares a single DelayTime-style programmable delay counter among NumRequesters clients. Each client raises a request with its own delay count. The arbiter grants one client at a time in round-robin order, drives the timer's start and speed inputs, and returns a one-cycle completion pulse to the granted client. It sits between the timing clients (LED/stepper/display sequencers) and one shared timer instance.

---
 rtl/delay_timer_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/delay_timer_arbiter.sv | 120 ++++++++++++
 tb/tb_delay_timer_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_timer_pkg.sv
// Shared definitions for the delay-timer arbiter: FSM state encoding and
// the default delay-count width of the shared timer.
package delay_timer_pkg;

    localparam int NUMBER_OF_BITS = 4;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_RUN  = 2'd1,
        STATE_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// searching upward (with wrap) from the slot just after last_idx.
module rr_pick #(
    parameter int NumRequesters = 4,
    parameter int IndexBits     = 2
) (
    input  logic [NumRequesters-1:0] request,
    input  logic [IndexBits-1:0]     last_idx,
    output logic                     valid,
    output logic [IndexBits-1:0]     idx
);

    always_comb begin
        int                       cand;
        logic [NumRequesters-1:0] cand_mask;
        valid     = 1'b0;
        idx       = '0;
        cand      = 0;
        cand_mask = '0;
        // last_idx itself is visited last, so the previous owner has lowest priority
        for (int k = 1; k <= NumRequesters; k++) begin
            cand      = (int'(last_idx) + k) % NumRequesters;
            cand_mask = NumRequesters'(1) << cand;
            if (!valid && (|(request & cand_mask))) begin
                valid = 1'b1;
                idx   = IndexBits'(cand);
            end
        end
    end

endmodule

// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one programmable delay timer among several
// clients; drives the timer's Start/Speed and returns a one-cycle Done pulse.
module delay_timer_arbiter
    import delay_timer_pkg::*;
#(
    parameter int NumberOfBits  = NUMBER_OF_BITS,
    parameter int NumRequesters = 4,
    parameter int IndexBits     = 2
) (
    input  logic                                  Clock,
    input  logic                                  Reset,
    input  logic [NumRequesters-1:0]              Request,
    input  logic [NumRequesters*NumberOfBits-1:0] SpeedIn,
    output logic [NumRequesters-1:0]              Grant,
    output logic [NumRequesters-1:0]              Done,
    output logic                                  Busy,
    output logic                                  TimerStart,
    output logic [NumberOfBits-1:0]               TimerSpeed,
    input  logic                                  TimerTimeout
);

    state_e                   state_q, state_d;
    logic [IndexBits-1:0]     idx_q, idx_d;
    logic [IndexBits-1:0]     last_idx_q, last_idx_d;
    logic [NumRequesters-1:0] grant_q, grant_d;
    logic [NumRequesters-1:0] done_q, done_d;
    logic                     start_q, start_d;
    logic [NumberOfBits-1:0]  speed_q, speed_d;

    logic                     pick_valid;
    logic [IndexBits-1:0]     pick_idx;
    logic [NumRequesters-1:0][NumberOfBits-1:0] speed_arr;

    assign speed_arr = SpeedIn;

    rr_pick #(
        .NumRequesters(NumRequesters),
        .IndexBits    (IndexBits)
    ) u_rr_pick (
        .request (Request),
        .last_idx(last_idx_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        grant_d    = grant_q;
        done_d     = '0;
        start_d    = start_q;
        speed_d    = speed_q;
        unique case (state_q)
            STATE_IDLE: begin
                grant_d = '0;
                start_d = 1'b0;
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    speed_d = speed_arr[pick_idx];
                    grant_d = NumRequesters'(1) << pick_idx;
                    start_d = 1'b1;
                    state_d = STATE_RUN;
                end
            end
            STATE_RUN: begin
                // Timeout takes priority over a same-cycle abort
                if (TimerTimeout) begin
                    done_d  = grant_q;
                    start_d = 1'b0;
                    state_d = STATE_DONE;
                end else if (!(|(Request & grant_q))) begin
                    grant_d    = '0;
                    start_d    = 1'b0;
                    last_idx_d = idx_q;
                    state_d    = STATE_IDLE;
                end
            end
            STATE_DONE: begin
                // Start stays low here, so the timer count clears before the next grant
                grant_d    = '0;
                start_d    = 1'b0;
                last_idx_d = idx_q;
                state_d    = STATE_IDLE;
            end
            default: begin
                grant_d = '0;
                start_d = 1'b0;
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= STATE_IDLE;
            idx_q      <= '0;
            last_idx_q <= IndexBits'(NumRequesters - 1);
            grant_q    <= '0;
            done_q     <= '0;
            start_q    <= 1'b0;
            speed_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            start_q    <= start_d;
            speed_q    <= speed_d;
        end
    end

    assign Grant      = grant_q;
    assign Done       = done_q;
    assign Busy       = (state_q != STATE_IDLE);
    assign TimerStart = start_q;
    assign TimerSpeed = speed_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Bench for delay_timer_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of round-robin grants and delay lengths.
module tb_delay_timer_arbiter;

    localparam int NB = 4;
    localparam int NR = 4;
    localparam int IB = 2;
    localparam int SW = NR * NB;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic [NR-1:0] Request = '0;
    logic [SW-1:0] SpeedIn = '0;
    logic [NR-1:0] Grant, Done;
    logic          Busy, TimerStart, TimerTimeout;
    logic [NB-1:0] TimerSpeed;
    logic [NB-1:0] tcnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clock = ~Clock;

    delay_timer_arbiter #(
        .NumberOfBits (NB),
        .NumRequesters(NR),
        .IndexBits    (IB)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Request     (Request),
        .SpeedIn     (SpeedIn),
        .Grant       (Grant),
        .Done        (Done),
        .Busy        (Busy),
        .TimerStart  (TimerStart),
        .TimerSpeed  (TimerSpeed),
        .TimerTimeout(TimerTimeout)
    );

    // Shared timer: counts while Start is high, clears while low.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)          tcnt <= '0;
        else if (TimerStart) tcnt <= tcnt + 1'b1;
        else                 tcnt <= '0;
    end
    assign TimerTimeout = (tcnt == NB'(TimerSpeed - 1'b1));

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset   = 1'b0;
        Request = '0;
        SpeedIn = '0;
        tick();
        Reset = 1'b1;
    endtask

    function automatic int model_pick(logic [NR-1:0] r, int last);
        for (int k = 1; k <= NR; k++)
            if (r[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    task automatic test_reset();
        Reset   = 1'b0;
        Request = '1;
        SpeedIn = {NR{4'd5}};
        tick();
        tick();
        n_chk++; if (Grant !== '0) $display("FAIL reset_grant: got %b want 0000", Grant); else n_pass++;
        n_chk++; if (Done !== '0) $display("FAIL reset_done: got %b want 0000", Done); else n_pass++;
        n_chk++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else n_pass++;
        n_chk++; if (TimerStart !== 1'b0) $display("FAIL reset_start: got %b want 0", TimerStart); else n_pass++;
        n_chk++; if (TimerSpeed !== '0) $display("FAIL reset_speed: got %0d want 0", TimerSpeed); else n_pass++;
        #2 Reset = 1'b1;
        tick();
        n_chk++; if (Grant !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", Grant); else n_pass++;
        n_chk++; if (TimerStart !== 1'b1) $display("FAIL reset_first_start: got %b want 1", TimerStart); else n_pass++;
        n_chk++; if (TimerSpeed !== 4'd5) $display("FAIL reset_first_speed: got %0d want 5", TimerSpeed); else n_pass++;
    endtask

    task automatic test_single();
        logic [NR-1:0] exp_g, exp_d;
        do_reset();
        SpeedIn[2*NB +: NB] = 4'd3;
        Request = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_g = (k <= 4) ? 4'b0100 : 4'b0000;
            exp_d = (k == 4) ? 4'b0100 : 4'b0000;
            n_chk++; if (Grant !== exp_g) $display("FAIL single_grant k=%0d: got %b want %b", k, Grant, exp_g); else n_pass++;
            n_chk++; if (Done !== exp_d) $display("FAIL single_done k=%0d: got %b want %b", k, Done, exp_d); else n_pass++;
            n_chk++; if (TimerStart !== (k <= 3)) $display("FAIL single_start k=%0d: got %b want %b", k, TimerStart, (k <= 3)); else n_pass++;
            if (k <= 3) begin
                n_chk++; if (TimerSpeed !== 4'd3) $display("FAIL single_speed k=%0d: got %0d want 3", k, TimerSpeed); else n_pass++;
            end
            if (k == 4) Request = '0;
        end
    endtask

    task automatic test_boundary();
        logic [NB-1:0] spd [2];
        int            got;
        spd[0] = 4'd1;
        spd[1] = 4'd0;
        for (int j = 0; j < 2; j++) begin
            do_reset();
            SpeedIn[NB-1:0] = spd[j];
            Request = 4'b0001;
            got = -1;
            for (int k = 1; k <= 40 && got < 0; k++) begin
                tick();
                if (Done !== '0) got = k;
            end
            Request = '0;
            n_chk++;
            if (got != ((spd[j] == 0) ? (1 << NB) : int'(spd[j])) + 1)
                $display("FAIL boundary_done speed=%0d: done at t+%0d want t+%0d", spd[j], got,
                         ((spd[j] == 0) ? (1 << NB) : int'(spd[j])) + 1);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int            dk [2];
        logic [NR-1:0] dv [2];
        int            nd;
        do_reset();
        dk[0] = -1; dk[1] = -1; dv[0] = '0; dv[1] = '0; nd = 0;
        SpeedIn = {NR{4'd3}};
        Request = 4'b0011;
        for (int k = 1; k <= 20 && nd < 2; k++) begin
            tick();
            if (Done !== '0) begin
                dk[nd] = k;
                dv[nd] = Done;
                nd++;
                Request = Request & ~Done;
            end
        end
        n_chk++; if (dk[0] != 4) $display("FAIL b2b_first_time: got t+%0d want t+4", dk[0]); else n_pass++;
        n_chk++; if (dv[0] !== 4'b0001) $display("FAIL b2b_first_client: got %b want 0001", dv[0]); else n_pass++;
        n_chk++; if (dk[1] != 9) $display("FAIL b2b_second_time: got t+%0d want t+9", dk[1]); else n_pass++;
        n_chk++; if (dv[1] !== 4'b0010) $display("FAIL b2b_second_client: got %b want 0010", dv[1]); else n_pass++;
        Request = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int            dk [4];
        logic [NR-1:0] dv [4];
        logic [NR-1:0] ord [4];
        int            nd;
        ord[0] = 4'b0001; ord[1] = 4'b0010; ord[2] = 4'b1000; ord[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin dk[i] = -1; dv[i] = '0; end
        nd = 0;
        do_reset();
        SpeedIn = {NR{4'd2}};
        Request = 4'b1011;
        for (int k = 1; k <= 40 && nd < 4; k++) begin
            tick();
            if (Done !== '0) begin
                dk[nd] = k;
                dv[nd] = Done;
                nd++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (dv[i] !== ord[i]) $display("FAIL rr_order #%0d: got %b want %b", i, dv[i], ord[i]); else n_pass++;
            n_chk++; if (dk[i] != 3 + 4 * i) $display("FAIL rr_time #%0d: got t+%0d want t+%0d", i, dk[i], 3 + 4 * i); else n_pass++;
        end
        Request = '0;
        tick();
        tick();
    endtask

    task automatic test_abort();
        logic [NR-1:0] done_seen;
        do_reset();
        done_seen = '0;
        SpeedIn[1*NB +: NB] = 4'd9;
        SpeedIn[2*NB +: NB] = 4'd5;
        Request = 4'b0110;
        tick();
        done_seen |= Done;
        n_chk++; if (Grant !== 4'b0010) $display("FAIL abort_grant1: got %b want 0010", Grant); else n_pass++;
        tick();
        done_seen |= Done;
        Request[1] = 1'b0;
        tick();
        done_seen |= Done;
        n_chk++; if (Grant !== 4'b0000) $display("FAIL abort_grant_drop: got %b want 0000", Grant); else n_pass++;
        n_chk++; if (TimerStart !== 1'b0) $display("FAIL abort_start_drop: got %b want 0", TimerStart); else n_pass++;
        n_chk++; if (done_seen !== 4'b0000) $display("FAIL abort_no_done: got %b want 0000", done_seen); else n_pass++;
        tick();
        n_chk++; if (Grant !== 4'b0100) $display("FAIL abort_next_grant: got %b want 0100", Grant); else n_pass++;
        n_chk++; if (TimerSpeed !== 4'd5) $display("FAIL abort_next_speed: got %0d want 5", TimerSpeed); else n_pass++;
        Request = '0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        logic [NR-1:0] done_seen;
        do_reset();
        SpeedIn[NB-1:0] = 4'd1;
        Request = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (Done !== '0) Request = '0;
        end
        SpeedIn[2*NB +: NB] = 4'd8;
        Request = 4'b0100;
        done_seen = '0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            done_seen |= Done;
        end
        n_chk++; if (Grant !== 4'b0100) $display("FAIL areset_pre_grant: got %b want 0100", Grant); else n_pass++;
        #3 Reset = 1'b0;
        #1;
        n_chk++; if (Grant !== '0) $display("FAIL areset_grant: got %b want 0000", Grant); else n_pass++;
        n_chk++; if (TimerStart !== 1'b0) $display("FAIL areset_start: got %b want 0", TimerStart); else n_pass++;
        n_chk++; if (Busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", Busy); else n_pass++;
        done_seen |= Done;
        Reset   = 1'b1;
        Request = 4'b0011;
        tick();
        done_seen |= Done;
        n_chk++; if (Grant !== 4'b0001) $display("FAIL areset_after_grant: got %b want 0001", Grant); else n_pass++;
        n_chk++; if (done_seen !== '0) $display("FAIL areset_no_done: got %b want 0000", done_seen); else n_pass++;
        Request = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int            owner, done_e, next_arb, last, seff;
        logic [NR-1:0] req_s, exp_g, exp_d;
        logic [SW-1:0] spd_s;
        logic [NB-1:0] lat_spd;
        logic          exp_s;
        do_reset();
        owner = -1; done_e = 0; next_arb = 0; last = NR - 1; lat_spd = '0;
        for (int e = 1; e <= 800; e++) begin
            req_s = Request;
            spd_s = SpeedIn;
            tick();
            if (owner < 0 && e >= next_arb && req_s != '0) begin
                owner   = model_pick(req_s, last);
                lat_spd = spd_s[owner*NB +: NB];
                seff    = (lat_spd == 0) ? (1 << NB) : int'(lat_spd);
                done_e  = e + seff;
            end
            exp_g = (owner >= 0) ? (NR'(1) << owner) : '0;
            exp_d = (owner >= 0 && e == done_e) ? exp_g : '0;
            exp_s = (owner >= 0 && e < done_e);
            n_chk++; if (Grant !== exp_g) $display("FAIL rand_grant e=%0d: got %b want %b", e, Grant, exp_g); else n_pass++;
            n_chk++; if (Done !== exp_d) $display("FAIL rand_done e=%0d: got %b want %b", e, Done, exp_d); else n_pass++;
            n_chk++; if (TimerStart !== exp_s) $display("FAIL rand_start e=%0d: got %b want %b", e, TimerStart, exp_s); else n_pass++;
            n_chk++; if (Busy !== (owner >= 0)) $display("FAIL rand_busy e=%0d: got %b want %b", e, Busy, (owner >= 0)); else n_pass++;
            if (exp_s) begin
                n_chk++; if (TimerSpeed !== lat_spd) $display("FAIL rand_speed e=%0d: got %0d want %0d", e, TimerSpeed, lat_spd); else n_pass++;
            end
            if (owner >= 0 && e == done_e) begin
                if ($urandom_range(0, 1) == 0) Request[owner] = 1'b0;
                last     = owner;
                owner    = -1;
                next_arb = e + 2;
            end
            for (int i = 0; i < NR; i++)
                if (!Request[i] && $urandom_range(0, 3) == 0) Request[i] = 1'b1;
            SpeedIn = SW'($urandom);
        end
        Request = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_back_to_back();
        test_round_robin();
        test_abort();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
